mem_instru_param: RTL and testbench

MEM_INSTRU_PARAM -- requirements
Module: mem_instru_param

---
 rtl/mem_pkg.sv | 12 +
 rtl/mem_instru_array.sv | 34 +++
 rtl/mem_instru_param.sv | 131 +++++++++++++
 tb/tb_mem_instru_param.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the instruction memory: fetch FSM encoding and default base address.
// No timing of its own; used by mem_instru_param.
package mem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h0040_0000;
  localparam int          WAIT_CNT_W    = 3;
endpackage

// File: rtl/mem_instru_array.sv
// Word storage for the instruction memory: synchronous write, registered read.
// Read data appears one cycle after rd_en; a same-cycle write to the read word returns the old word.
module mem_instru_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents survive reset so a loaded program is kept across a core reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/mem_instru_param.sv
// Instruction fetch memory with alignment/range checks and programmable wait states.
// Latency WAIT_STATES+1 cycles; busy during wait states, requests then ignored; 1/cycle when WAIT_STATES=0.
module mem_instru_param
  import mem_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(BASE_ADDR_DEF),
  parameter int                WAIT_STATES = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ReadMem,
  input  logic [ADDR_W-1:0]        Dir_Instru,
  output logic                     busy,
  output logic [DATA_W-1:0]        Dato_Instru,
  output logic                     dato_valid,
  output logic                     err_align,
  output logic                     err_rango,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [DATA_W-1:0]        wr_data
);

  localparam int                    IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0]     SPAN     = ADDR_W'(4 * DEPTH);
  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1)
                                                                 : '0;

  fetch_state_t          state, state_nxt;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [ADDR_W-1:0]     addr_q;
  logic                  accept;
  logic                  rd_go;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [ADDR_W-1:0]     rd_off;
  logic                  rd_misal;
  logic                  rd_oor;
  logic                  err_align_q;
  logic                  err_rango_q;
  logic [DATA_W-1:0]     rd_data;

  assign accept = !ReadMem && (state == IDLE || state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: begin
        if (!ReadMem) begin
          state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    dato_valid = 1'b0;
    case (state)
      WAIT:    busy       = 1'b1;
      RESP:    dato_valid = 1'b1;
      default: ;
    endcase
  end

  // The array is read on the edge that enters RESP; from WAIT the captured address is used.
  assign rd_go    = (state_nxt == RESP);
  assign rd_addr  = (state == WAIT) ? addr_q : Dir_Instru;
  assign rd_off   = rd_addr - BASE_ADDR;
  assign rd_misal = |rd_addr[1:0];
  assign rd_oor   = (rd_off >= SPAN);
  assign rd_en    = rd_go && !rd_misal && !rd_oor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      addr_q      <= '0;
      err_align_q <= 1'b0;
      err_rango_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= Dir_Instru;
        wait_cnt <= CNT_LOAD;
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
      end
      if (rd_go) begin
        err_align_q <= rd_misal;
        err_rango_q <= rd_oor;
      end
    end
  end

  mem_instru_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_idx  (rd_off[IDX_W+1:2]),
    .rd_data (rd_data)
  );

  // Faulted fetches skip the array, so the stale read register is masked to zero.
  assign Dato_Instru = (err_align_q || err_rango_q) ? '0 : rd_data;
  assign err_align   = err_align_q;
  assign err_rango   = err_rango_q;

endmodule

// File: tb/tb_mem_instru_param.sv
// Self-checking bench: one instance with no wait states and one with three, sharing stimulus.
// A time-based reference model predicts every response; directed steps pin literal values.
module tb_mem_instru_param;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk, rst_n, ReadMem, wr_en;
  logic [31:0] Dir_Instru, wr_data;
  logic [5:0]  wr_idx;

  logic        busy0, valid0, ea0, er0;
  logic [31:0] data0;
  logic        busy3, valid3, ea3, er3;
  logic [31:0] data3;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  mem_instru_param #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ReadMem(ReadMem), .Dir_Instru(Dir_Instru),
    .busy(busy0), .Dato_Instru(data0), .dato_valid(valid0),
    .err_align(ea0), .err_rango(er0),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
  );

  mem_instru_param #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ReadMem(ReadMem), .Dir_Instru(Dir_Instru),
    .busy(busy3), .Dato_Instru(data3), .dato_valid(valid3),
    .err_align(ea3), .err_rango(er3),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: a fetch accepted at edge c answers in the interval after edge c+N.
  int          ns [2] = '{0, 3};
  int          cyc = 0;
  logic [31:0] mem_m [64];
  bit          pend_vld [2];
  int          pend_resp [2];
  logic [31:0] pend_addr [2];
  bit          exp_valid [2];
  bit          exp_busy [2];
  logic [31:0] exp_data [2];
  bit          exp_ea [2];
  bit          exp_er [2];
  logic [31:0] m_off;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        pend_vld[k]  = 0;
        exp_valid[k] = 0;
        exp_busy[k]  = 0;
        exp_data[k]  = 0;
        exp_ea[k]    = 0;
        exp_er[k]    = 0;
      end else begin
        if (!ReadMem && !pend_vld[k]) begin
          pend_vld[k]  = 1;
          pend_resp[k] = cyc + ns[k];
          pend_addr[k] = Dir_Instru;
        end
        exp_valid[k] = 0;
        if (pend_vld[k] && pend_resp[k] == cyc) begin
          m_off        = pend_addr[k] - BASE;
          exp_ea[k]    = (pend_addr[k] % 4) != 0;
          exp_er[k]    = m_off >= 32'd256;
          exp_data[k]  = (exp_ea[k] || exp_er[k]) ? 32'h0 : mem_m[m_off / 4];
          exp_valid[k] = 1;
          pend_vld[k]  = 0;
        end
        exp_busy[k] = pend_vld[k];
      end
    end
    if (wr_en) mem_m[wr_idx] = wr_data;
    cyc++;
  end

  task automatic cmp(input int k, input logic v, input logic b, input logic [31:0] d,
                     input logic ea, input logic er);
    string s;
    s = (k == 0) ? "ws0" : "ws3";
    chk({s, ".valid"}, 32'(v), 32'(exp_valid[k]));
    chk({s, ".busy"}, 32'(b), 32'(exp_busy[k]));
    if (exp_valid[k] || !rst_n) begin
      chk({s, ".data"}, d, exp_data[k]);
      chk({s, ".err_align"}, 32'(ea), 32'(exp_ea[k]));
      chk({s, ".err_rango"}, 32'(er), 32'(exp_er[k]));
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, valid0, busy0, data0, ea0, er0);
      cmp(1, valid3, busy3, data3, ea3, er3);
    end
  end

  task automatic idle(input int n);
    ReadMem = 1;
    wr_en   = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic fetch_one(input logic [31:0] a);
    ReadMem    = 0;
    Dir_Instru = a;
    @(negedge clk);
    ReadMem = 1;
  endtask

  // Bounded wait for the 3-wait-state instance; checks the returned word.
  task automatic expect_ws3(input string name, input logic [31:0] d);
    bit got;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (valid3) begin
        got = 1;
        chk({name, ".data"}, data3, d);
      end else begin
        @(negedge clk);
      end
    end
    chk({name, ".seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    int bn, vn;
    clk = 0; rst_n = 0; ReadMem = 1; Dir_Instru = 0;
    wr_en = 0; wr_idx = 0; wr_data = 0;
    repeat (3) @(negedge clk);
    chk("rst.valid0", 32'(valid0), 0);
    chk("rst.busy0", 32'(busy0), 0);
    chk("rst.data0", data0, 0);
    chk("rst.errs0", 32'({ea0, er0}), 0);
    chk("rst.valid3", 32'(valid3), 0);
    chk("rst.busy3", 32'(busy3), 0);
    chk("rst.data3", data3, 0);
    chk("rst.errs3", 32'({ea3, er3}), 0);
    rst_n  = 1;
    chk_en = 1;

    for (int i = 0; i < 64; i++) begin
      wr_en   = 1;
      wr_idx  = 6'(i);
      wr_data = (i == 0) ? 32'h10 : (i == 1) ? 32'h0100_0110 : (i == 2) ? 32'h0100_100B : $urandom;
      @(negedge clk);
    end
    idle(2);

    // Basic fetch, no wait states.
    fetch_one(32'h0040_0004);
    chk("basic.valid", 32'(valid0), 1);
    chk("basic.data", data0, 32'h0100_0110);
    chk("basic.errs", 32'({ea0, er0}), 0);
    idle(6);

    // Three wait states with a request pulse while busy.
    ReadMem    = 0;
    Dir_Instru = 32'h0040_0008;
    @(negedge clk);
    bn = 0; vn = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid3) begin
        vn++;
        if (vn == 1) begin
          chk("ws.data", data3, 32'h0100_100B);
          chk("ws.cycle", i, 3);
        end
      end
      if (busy3) bn++;
      ReadMem    = (i != 1);
      Dir_Instru = 32'h0040_0000;
      @(negedge clk);
    end
    ReadMem = 1;
    chk("ws.busy_cycles", bn, 3);
    chk("ws.valid_cycles", vn, 1);
    idle(4);

    // Error flags.
    fetch_one(32'h0040_0006);
    chk("align.flags", 32'({ea0, er0}), 32'b10);
    chk("align.data", data0, 0);
    idle(5);
    fetch_one(32'h0040_0100);
    chk("rango_hi.flags", 32'({ea0, er0}), 32'b01);
    chk("rango_hi.data", data0, 0);
    idle(5);
    fetch_one(32'h003F_FFFC);
    chk("rango_lo.flags", 32'({ea0, er0}), 32'b01);
    chk("rango_lo.data", data0, 0);
    idle(5);

    // Back-to-back stream.
    ReadMem = 0; Dir_Instru = 32'h0040_0000;
    @(negedge clk);
    chk("b2b0", {31'b0, valid0} == 1 ? data0 : 32'hFFFF_FFFF, 32'h10);
    Dir_Instru = 32'h0040_0004;
    @(negedge clk);
    chk("b2b1", {31'b0, valid0} == 1 ? data0 : 32'hFFFF_FFFF, 32'h0100_0110);
    Dir_Instru = 32'h0040_0008;
    @(negedge clk);
    chk("b2b2", {31'b0, valid0} == 1 ? data0 : 32'hFFFF_FFFF, 32'h0100_100B);
    idle(6);

    // Write to the word being read in the same cycle.
    ReadMem = 0; Dir_Instru = 32'h0040_0004;
    wr_en = 1; wr_idx = 6'd1; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    ReadMem = 1; wr_en = 0;
    chk("rbw.old", data0, 32'h0100_0110);
    idle(5);
    fetch_one(32'h0040_0004);
    chk("rbw.new", data0, 32'hDEAD_BEEF);
    idle(5);

    // Reset in the middle of a wait-state fetch.
    fetch_one(32'h0040_0008);
    @(negedge clk);
    chk("rstmid.busy_before", 32'(busy3), 1);
    #2 rst_n = 0;
    #1;
    chk("rstmid.busy", 32'(busy3), 0);
    chk("rstmid.valid", 32'(valid3), 0);
    chk("rstmid.data", data3, 0);
    chk("rstmid.errs", 32'({ea3, er3}), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    vn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid3) vn++;
    end
    chk("rstmid.no_valid", vn, 0);
    fetch_one(32'h0040_0000);
    chk("keep0.ws0", data0, 32'h10);
    expect_ws3("keep0.ws3", 32'h10);
    idle(2);
    fetch_one(32'h0040_0004);
    expect_ws3("keep1.ws3", 32'hDEAD_BEEF);
    idle(2);
    fetch_one(32'h0040_0008);
    expect_ws3("keep2.ws3", 32'h0100_100B);
    idle(2);

    // Randomized traffic against the model.
    repeat (600) begin
      int r;
      r       = $urandom_range(0, 9);
      ReadMem = ($urandom_range(0, 3) == 0);
      case (r)
        0:       Dir_Instru = BASE + $urandom_range(0, 255);
        1:       Dir_Instru = BASE - 4 * $urandom_range(1, 8);
        2:       Dir_Instru = BASE + 256 + 4 * $urandom_range(0, 16);
        default: Dir_Instru = BASE + 4 * $urandom_range(0, 63);
      endcase
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_idx  = 6'($urandom_range(0, 63));
      wr_data = $urandom;
      @(negedge clk);
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
